fc_weight_stream_ctrl: RTL and testbench

Sequencer for a generated weight ROM (`<layer>_weight` wrapper, 2-cycle read latency, `ce0`-gated pipeline). It replaces the free-running counter and constant-valid source with a start/done-controlled, backpressure-safe weight stream. The stream repeats the full weight tensor a programmable number of passes and never drops or duplicates a beat when the consumer stalls. It sits between the ROM wrapper and the linear-layer weight input.

---
 rtl/fc_weight_stream_ctrl.sv | 173 +++++++++++++++++
 tb/tb_fc_weight_stream_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/fc_weight_stream_ctrl.sv
// Start/done sequencer that streams a ROM-resident weight tensor a programmable number of passes
// through a small output FIFO, throttling ROM reads so stalled beats are never lost or duplicated.
module fc_weight_stream_ctrl #(
    parameter int DATA_WIDTH  = 16,
    parameter int PARALLELISM = 1,
    parameter int OUT_DEPTH   = 32,
    parameter int ADDR_WIDTH  = $clog2(OUT_DEPTH + 1),
    parameter int ROM_LATENCY = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [15:0]                       repeat_count,
    output logic                              busy,
    output logic                              done,
    output logic [ADDR_WIDTH-1:0]             rom_address,
    output logic                              rom_ce,
    input  logic [DATA_WIDTH*PARALLELISM-1:0] rom_q,
    output logic [DATA_WIDTH-1:0]             data_out [PARALLELISM],
    output logic                              data_out_valid,
    input  logic                              data_out_ready
);

    localparam int WORD_W = DATA_WIDTH * PARALLELISM;
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W:0]      DEPTH_C   = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(OUT_DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [15:0]             r_pass;
    logic [15:0]             r_repeat;
    logic [ROM_LATENCY-1:0]  r_tag;
    logic [CNT_W-1:0]        r_inflight;
    logic [CNT_W-1:0]        r_count;
    logic [PTR_W-1:0]        r_wr_ptr;
    logic [PTR_W-1:0]        r_rd_ptr;
    logic [WORD_W-1:0]       r_mem [FIFO_DEPTH];

    logic                    w_issue;
    logic                    w_start_accept;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_addr_wrap;
    logic                    w_last_pass;
    logic [CNT_W:0]          w_outstanding;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Throttle uses only registered counts, so outstanding reads never exceed the FIFO room.
    assign w_outstanding = {1'b0, r_inflight} + {1'b0, r_count};
    assign w_addr_wrap   = (r_addr == LAST_ADDR);
    assign w_last_pass   = (r_pass == r_repeat - 16'd1);
    assign w_push        = r_tag[ROM_LATENCY-1];
    assign w_pop         = data_out_valid && data_out_ready;
    assign data_out_valid = (r_count != '0);
    assign rom_address   = r_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_issue        = 1'b0;
        w_start_accept = 1'b0;
        busy           = 1'b0;
        done           = 1'b0;
        rom_ce         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_start_accept = 1'b1;
                    w_state_next   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                rom_ce = 1'b1;
                busy   = 1'b1;
                if (w_outstanding < DEPTH_C) begin
                    w_issue = 1'b1;
                    if (w_addr_wrap && w_last_pass) begin
                        w_state_next = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                rom_ce = 1'b1;
                // Completion coincides with busy falling, one cycle after the last handshake.
                if (r_inflight == '0 && r_count == '0) begin
                    done         = 1'b1;
                    w_state_next = S_IDLE;
                end else begin
                    busy = 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr   <= '0;
            r_pass   <= '0;
            r_repeat <= '0;
        end else if (w_start_accept) begin
            r_addr   <= '0;
            r_pass   <= '0;
            r_repeat <= (repeat_count == 16'd0) ? 16'd1 : repeat_count;
        end else if (w_issue) begin
            if (w_addr_wrap) begin
                r_addr <= '0;
                r_pass <= r_pass + 16'd1;
            end else begin
                r_addr <= r_addr + ADDR_WIDTH'(1);
            end
        end
    end

    // Each tag bit marks a ROM read whose q0 arrives ROM_LATENCY cycles after issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tag      <= '0;
            r_inflight <= '0;
        end else begin
            r_tag      <= (r_tag << 1) | ROM_LATENCY'(w_issue);
            r_inflight <= r_inflight + CNT_W'(w_issue) - CNT_W'(w_push);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= rom_q;
                r_wr_ptr        <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < PARALLELISM; gi++) begin : g_lane
            assign data_out[gi] = r_mem[r_rd_ptr][DATA_WIDTH*gi +: DATA_WIDTH];
        end
    endgenerate

endmodule

// File: tb/tb_fc_weight_stream_ctrl.sv
// Bench for fc_weight_stream_ctrl: 8-word ROM holding word k = k, table of sequences plus
// hand-written reset cases, all beats checked against an expected-order scoreboard.
module tb_fc_weight_stream_ctrl;

    localparam int DW    = 16;
    localparam int DEPTH = 8;
    localparam int AW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [15:0]   repeat_count;
    logic          busy;
    logic          done;
    logic [AW-1:0] rom_address;
    logic          rom_ce;
    logic [DW-1:0] rom_q;
    logic [DW-1:0] data_out [1];
    logic          data_out_valid;
    logic          data_out_ready;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fc_weight_stream_ctrl #(
        .DATA_WIDTH (DW),
        .PARALLELISM(1),
        .OUT_DEPTH  (DEPTH),
        .ROM_LATENCY(2),
        .FIFO_DEPTH (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .repeat_count  (repeat_count),
        .busy          (busy),
        .done          (done),
        .rom_address   (rom_address),
        .rom_ce        (rom_ce),
        .rom_q         (rom_q),
        .data_out      (data_out),
        .data_out_valid(data_out_valid),
        .data_out_ready(data_out_ready)
    );

    // Two-stage ce-gated ROM: word k holds value k.
    logic [AW-1:0] rom_a_q = '0;
    always @(posedge clk) begin
        if (rom_ce) begin
            rom_a_q <= rom_address;
            rom_q   <= DW'(rom_a_q);
        end
    end

    typedef struct {
        int rep;
        int mode;      // 0 ready high, 1 random ready, 2 ready low 20 cycles then high
        bit poke;      // hold start high while busy
        int exp_beats;
        int exp_done;
        int exp_lat;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_rom_ce"}, int'(rom_ce), 0);
        chk({tag, "_rom_address"}, int'(rom_address), 0);
        chk({tag, "_valid"}, int'(data_out_valid), 0);
        chk({tag, "_data"}, int'(data_out[0]), 0);
    endtask

    task automatic run_seq(input vec_t v, input string tag);
        int exp_q[$];
        int n_rep, cyc, first_valid, last_hs, done_cyc, n_done, n_hs, n_issue;
        int max_out, stall_bad, exp_v;
        logic [AW-1:0] prev_addr;
        logic [DW-1:0] prev_data;
        bit prev_stall, finished;

        n_rep = (v.rep == 0) ? 1 : v.rep;
        for (int p = 0; p < n_rep; p++)
            for (int k = 0; k < DEPTH; k++)
                exp_q.push_back(k);

        @(posedge clk); #1;
        start          = 1'b1;
        repeat_count   = 16'(v.rep);
        data_out_ready = (v.mode == 0) ? 1'b1 : (v.mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        cyc = 0; first_valid = -1; last_hs = -1; done_cyc = -1; n_done = 0;
        n_hs = 0; n_issue = 0; max_out = 0; stall_bad = 0;
        prev_addr = rom_address; prev_data = '0; prev_stall = 0; finished = 0;

        while (!finished) begin
            @(negedge clk);
            if (cyc == 0) chk({tag, "_busy_in_start_cycle"}, int'(busy), 0);
            if (cyc == 1) begin
                chk({tag, "_busy_after_start"}, int'(busy), 1);
                chk({tag, "_ce_after_start"}, int'(rom_ce), 1);
                chk({tag, "_addr_first_issue"}, int'(rom_address), 0);
            end
            if (rom_address != prev_addr) n_issue++;
            prev_addr = rom_address;
            if (n_issue - n_hs > max_out) max_out = n_issue - n_hs;
            if (prev_stall && (!data_out_valid || data_out[0] != prev_data)) stall_bad++;
            if (data_out_valid && first_valid < 0) first_valid = cyc;
            if (data_out_valid && data_out_ready) begin
                exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
                chk($sformatf("%s_beat%0d", tag, n_hs), int'(data_out[0]), exp_v);
                n_hs++;
                last_hs = cyc;
            end
            prev_stall = data_out_valid && !data_out_ready;
            prev_data  = data_out[0];
            if (done) begin
                n_done++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    chk({tag, "_busy_at_done"}, int'(busy), 0);
                end
            end
            if (v.mode == 2 && cyc == 20) begin
                chk({tag, "_held_addr"}, int'(rom_address), 4);
                chk({tag, "_held_issues"}, n_issue, 4);
                chk({tag, "_held_valid"}, int'(data_out_valid), 1);
                chk({tag, "_held_data"}, int'(data_out[0]), 0);
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 4) finished = 1;
            if (cyc >= 3000) begin
                chk({tag, "_timeout"}, cyc, -1);
                finished = 1;
            end
            cyc++;
            @(posedge clk); #1;
            start = v.poke && (done_cyc < 0);
            case (v.mode)
                0:       data_out_ready = 1'b1;
                1:       data_out_ready = 1'($urandom_range(0, 1));
                default: data_out_ready = (cyc > 20);
            endcase
        end
        start = 1'b0;

        chk({tag, "_beats"}, n_hs, v.exp_beats);
        chk({tag, "_issues"}, n_issue, v.exp_beats);
        chk({tag, "_done_pulses"}, n_done, v.exp_done);
        chk({tag, "_first_valid_lat"}, first_valid, v.exp_lat);
        chk({tag, "_done_after_last_beat"}, done_cyc - last_hs, 1);
        chk({tag, "_outstanding_le_4"}, int'(max_out <= 4), 1);
        chk({tag, "_stall_stable"}, stall_bad, 0);
        if (v.mode == 0) chk({tag, "_bubbles"}, (last_hs - first_valid + 1) - n_hs, 0);
        $display("seq %s rep=%0d mode=%0d beats=%0d dones=%0d max_outstanding=%0d",
                 tag, v.rep, v.mode, n_hs, n_done, max_out);
    endtask

    initial begin
        int got;
        vecs[0] = '{1, 0, 1'b0, 8, 1, 4};
        vecs[1] = '{3, 0, 1'b0, 24, 1, 4};
        vecs[2] = '{5, 1, 1'b0, 40, 1, 4};
        vecs[3] = '{1, 2, 1'b0, 8, 1, 4};
        vecs[4] = '{0, 0, 1'b0, 8, 1, 4};
        vecs[5] = '{2, 0, 1'b1, 16, 1, 4};
        vecs[6] = '{2, 1, 1'b1, 16, 1, 4};
        for (int i = 7; i < 10; i++) begin
            vecs[i].rep       = $urandom_range(1, 4);
            vecs[i].mode      = 1;
            vecs[i].poke      = (i == 9);
            vecs[i].exp_beats = DEPTH * vecs[i].rep;
            vecs[i].exp_done  = 1;
            vecs[i].exp_lat   = 4;
        end

        rst = 1'b1; start = 1'b0; repeat_count = '0; data_out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk_reset_outputs("idle");

        for (int i = 0; i < 10; i++) run_seq(vecs[i], $sformatf("v%0d", i));

        // Reset in the middle of a stream, then restart from address 0.
        @(posedge clk); #1;
        start = 1'b1; repeat_count = 16'd1; data_out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        got = 0;
        for (int i = 0; i < 100 && got == 0; i++) begin
            @(negedge clk);
            if (data_out_valid && data_out_ready && data_out[0] == 3) got = 1;
        end
        chk("midrst_beat3_seen", got, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk_reset_outputs("midrst");
        run_seq(vecs[0], "after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
